// File: rtl/hps_bank_scheduler_pkg.sv
// hps_pkg: shared types for the HPS ping-pong bank scheduler.
//   bank_state_e : per-bank life cycle EMPTY -> FILLING -> FULL -> READING -> EMPTY
//   wr_state_e   : magnitude-writer FSM states
//   rd_state_e   : HPS read-sequencer FSM states
//   K_WIDTH_DEF  : default DFT index width (2048-point FFT)
package hps_pkg;

  localparam int unsigned K_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    WR_SYNC,
    WR_ARM,
    WR_FILL,
    WR_DROP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_BUSY
  } rd_state_e;

endpackage

// File: rtl/hps_bank_scheduler_state.sv
// hps_bank_state: 2-bit life-cycle register for one magnitude RAM bank.
//   clock, reset : clock, asynchronous active-high reset (-> EMPTY)
//   fill         : writer claims the bank (EMPTY -> FILLING)
//   close        : writer finished the frame (FILLING -> FULL)
//   start        : reader claims the bank (FULL -> READING)
//   free         : reader finished the bank (READING -> EMPTY)
//   state        : current bank state (bank_state_e encoding)
module hps_bank_state
  import hps_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       fill,
  input  logic       close,
  input  logic       start,
  input  logic       free,
  output logic [1:0] state
);

  bank_state_e st;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= BANK_EMPTY;
    end else begin
      case (st)
        // fill and close together is a single-sample frame: straight to FULL
        BANK_EMPTY:   if (fill)  st <= close ? BANK_FULL : BANK_FILLING;
        BANK_FILLING: if (close) st <= BANK_FULL;
        BANK_FULL:    if (start) st <= BANK_READING;
        BANK_READING: if (free)  st <= BANK_EMPTY;
        default:                 st <= BANK_EMPTY;
      endcase
    end
  end

  assign state = st;

endmodule

// File: rtl/hps_bank_scheduler.sv
// hps_bank_scheduler: ping-pong scheduler for the two-bank HPS magnitude RAM.
// Frame N+1 is written into one bank while the HPS sequencer reads frame N
// from the other; frames with no free bank are dropped whole.
//   clock, reset       : clock, asynchronous active-high reset
//   wr_valid/last/k    : delayed FFT magnitude stream
//   wr_en, wr_addr     : RAM port A write strobe / {bank, k} address (registered)
//   hps_start          : one-cycle pulse to start reading bank hps_bank
//   hps_bank           : bank being read, stable from hps_start to hps_done
//   hps_done           : HPS sequencer finished its bank
//   frame_drop         : one-cycle pulse per discarded frame
//   drop_count         : saturating dropped-frame counter
//   frame_count        : wrapping count of frames handed to HPS
module hps_bank_scheduler
  import hps_pkg::*;
#(
  parameter int unsigned K_WIDTH     = K_WIDTH_DEF,
  parameter int unsigned DROP_CNT_W  = 8,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic                   wr_last,
  input  logic [K_WIDTH-1:0]     wr_k,
  output logic                   wr_en,
  output logic [K_WIDTH-1:0]     wr_addr,
  output logic                   hps_start,
  output logic                   hps_bank,
  input  logic                   hps_done,
  output logic                   frame_drop,
  output logic [DROP_CNT_W-1:0]  drop_count,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  wr_state_e             wr_state;
  rd_state_e             rd_state;
  logic                  wr_sel;
  logic                  rd_sel;
  logic [1:0]            bank_st [2];
  logic                  k_zero;
  logic                  wr_fill;
  logic                  wr_close;
  logic                  rd_start;
  logic                  rd_free;
  logic [DROP_CNT_W-1:0] drop_inc;

  // Bank handshakes are decoded combinationally so the bank registers and
  // the FSMs move on the same edge.
  always_comb begin
    k_zero   = (wr_k == '0);
    wr_fill  = (wr_state == WR_ARM) && wr_valid && k_zero && (bank_st[wr_sel] == BANK_EMPTY);
    wr_close = wr_valid && wr_last && (wr_fill || (wr_state == WR_FILL));
    rd_start = (rd_state == RD_IDLE) && (bank_st[rd_sel] == BANK_FULL);
    rd_free  = (rd_state == RD_BUSY) && hps_done;
    drop_inc = (drop_count == '1) ? drop_count : drop_count + 1'b1;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    hps_bank_state u_bank (
      .clock (clock),
      .reset (reset),
      .fill  (wr_fill  && (wr_sel == 1'(b))),
      .close (wr_close && (wr_sel == 1'(b))),
      .start (rd_start && (rd_sel == 1'(b))),
      .free  (rd_free  && (rd_sel == 1'(b))),
      .state (bank_st[b])
    );
  end

  // Writer: SYNC waits for a frame boundary, ARM decides store vs drop on k==0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state   <= WR_SYNC;
      wr_sel     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      frame_drop <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_drop <= 1'b0;
      case (wr_state)
        WR_SYNC: if (wr_valid && wr_last) wr_state <= WR_ARM;
        WR_ARM: begin
          if (wr_valid) begin
            if (!k_zero) begin
              wr_state <= WR_SYNC;
            end else if (wr_fill) begin
              wr_en   <= 1'b1;
              wr_addr <= {wr_sel, wr_k[K_WIDTH-2:0]};
              if (wr_last) wr_sel   <= ~wr_sel;
              else         wr_state <= WR_FILL;
            end else if (wr_last) begin
              frame_drop <= 1'b1;
              drop_count <= drop_inc;
            end else begin
              wr_state <= WR_DROP;
            end
          end
        end
        WR_FILL: begin
          // Only the lower half of the spectrum is stored.
          wr_en   <= wr_valid && !wr_k[K_WIDTH-1];
          wr_addr <= {wr_sel, wr_k[K_WIDTH-2:0]};
          if (wr_valid && wr_last) begin
            wr_sel   <= ~wr_sel;
            wr_state <= WR_ARM;
          end
        end
        WR_DROP: begin
          if (wr_valid && wr_last) begin
            frame_drop <= 1'b1;
            drop_count <= drop_inc;
            wr_state   <= WR_ARM;
          end
        end
        default: wr_state <= WR_SYNC;
      endcase
    end
  end

  // Reader: hands FULL banks to the HPS sequencer in wr_sel order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state    <= RD_IDLE;
      rd_sel      <= 1'b0;
      hps_start   <= 1'b0;
      hps_bank    <= 1'b0;
      frame_count <= '0;
    end else begin
      hps_start <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (rd_start) begin
            hps_bank    <= rd_sel;
            hps_start   <= 1'b1;
            frame_count <= frame_count + 1'b1;
            rd_state    <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (rd_free) begin
            rd_sel   <= ~rd_sel;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // The writer only ever touches a bank it owns.
  always_ff @(posedge clock) begin
    if (!reset && wr_valid && (wr_state == WR_FILL))
      assert (bank_st[wr_sel] == BANK_FILLING);
    if (!reset && wr_en)
      assert (bank_st[wr_addr[K_WIDTH-1]] != BANK_READING);
  end

endmodule
